sync_fifo_ram: RTL
==================

# sync_fifo_ram

Single-clock, parametrised FIFO built on an inferred simple dual-port block RAM with a registered read port. It is the successor of our plain dual-port RAM test block: same storage style and DIN/DOUT naming, now with pointer management, occupancy count, full/empty and programmable almost-flags, a read-valid strobe and sticky overflow/underflow error flags. It is used in the IO test designs as a buffer between a producer and consumer sharing one clock.

## Interface
- DATA_WIDTH, 36, word width in bits (1..72)
- ADDR_WIDTH, 9, address bits; DEPTH = 2**ADDR_WIDTH words (2..16)
- AFULL_THRESH, 2**ADDR_WIDTH-4, ALMOST_FULL asserts when COUNT >= this value (1..DEPTH)
- AEMPTY_THRESH, 4, ALMOST_EMPTY asserts when COUNT <= this value (0..DEPTH-1)

- CLK  in  1  sole clock; everything is on the rising edge
- RST  in  1  reset: one clock; reset is synchronous and active-high
- WE  in  1  write request
- DIN  in  DATA_WIDTH  write data
- RE  in  1  read request
- CLR_ERR  in  1  clears OVERFLOW/UNDERFLOW
- DOUT  out  DATA_WIDTH  read data, registered
- DOUT_VALID  out  1  one-cycle pulse: DOUT holds newly read word
- FULL  out  1  COUNT == DEPTH
- EMPTY  out  1  COUNT == 0
- ALMOST_FULL  out  1  COUNT >= AFULL_THRESH
- ALMOST_EMPTY  out  1  COUNT <= AEMPTY_THRESH
- COUNT  out  ADDR_WIDTH+1  words currently stored
- OVERFLOW  out  1  sticky: write attempted while FULL
- UNDERFLOW  out  1  sticky: read attempted while EMPTY

## Operation
- Storage: RAM[DEPTH] of DATA_WIDTH; not reset, contents undefined after power-up.
- Pointers wr_ptr, rd_ptr are ADDR_WIDTH bits and wrap DEPTH-1 -> 0; COUNT is a separate ADDR_WIDTH+1-bit register.
- Write accepted iff WE && !FULL (FULL as seen this cycle): RAM[wr_ptr] <= DIN, wr_ptr++.
- Read accepted iff RE && !EMPTY: DOUT <= RAM[rd_ptr], rd_ptr++, DOUT_VALID <= 1; otherwise DOUT holds, DOUT_VALID <= 0.
- Acceptance is judged on the current flags only. When FULL, a simultaneous read does not free space for the write in the same cycle, so the write is rejected. When EMPTY, a simultaneous write does not make the word readable in the same cycle, so the read is rejected.
- COUNT: +1 on write only, -1 on read only, unchanged on both or neither. It never leaves 0..DEPTH.
- Address collision cannot occur: an accepted read and write share an address only when COUNT == DEPTH, and the write is rejected then.
- Flags FULL/EMPTY/ALMOST_* are registered, computed from next-COUNT, so they always match the COUNT output in the same cycle.
- OVERFLOW <= 1 on WE && FULL; UNDERFLOW <= 1 on RE && EMPTY. Both clear on CLR_ERR; a set condition in the same cycle as CLR_ERR wins. Rejected requests change no other state.
- RST (sync, active-high) has priority over all requests. It resets:
  - pointers and COUNT to 0
  - DOUT to 0, DOUT_VALID to 0
  - EMPTY to 1, FULL to 0
  - ALMOST_EMPTY to 1, ALMOST_FULL to 0 (for AFULL_THRESH >= 1)
  - OVERFLOW and UNDERFLOW to 0
- Reset mid-operation discards all stored words; RAM is not cleared.

## Timing
- Write -> visible: a word written at edge N raises COUNT/clears EMPTY after edge N; it can be read by RE in the cycle after edge N, with data on DOUT after edge N+1.
- Read latency: RE accepted at edge N -> DOUT and DOUT_VALID valid in the cycle after edge N (1 cycle). Back-to-back reads give one word per cycle.
- Throughput: one write and one read per cycle, sustained, when 0 < COUNT < DEPTH.
- Flag/COUNT update latency: 1 edge after the accepting request; no combinational path from WE/RE to any output.
- RST asserted at edge N: all outputs take their reset values in the cycle after edge N; requests at edge N are ignored.

## Test plan
- Reset, then idle: with ADDR_WIDTH=4 -> COUNT=0, EMPTY=1, ALMOST_EMPTY=1, FULL=0, DOUT=0, DOUT_VALID=0, both error flags 0.
- Fill then drain: write 16 words 0x1..0x10 -> FULL=1, COUNT=16, ALMOST_FULL from COUNT=12. Then 16 reads -> DOUT 0x1..0x10 in order, one DOUT_VALID per word, EMPTY=1 at end.
- Wrap-around: 3 rounds of write 10 / read 10 with incrementing data -> data order preserved across pointer wrap, COUNT returns to 0.
- Simultaneous: at COUNT=5 with WE+RE for 8 cycles -> COUNT stays 5, reads return oldest words. At FULL with WE+RE -> write rejected, OVERFLOW=1, COUNT=15. At EMPTY with WE+RE -> read rejected, UNDERFLOW=1, COUNT=1.
- Errors: RE while EMPTY -> UNDERFLOW=1 and stays 1. CLR_ERR -> 0. CLR_ERR together with WE on FULL -> OVERFLOW remains 1.
- Reset mid-operation: at COUNT=7, RST for 1 cycle with WE/RE high -> COUNT=0, EMPTY=1, DOUT=0. The next write/read round-trips the new data only.

Source files
------------

// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO on an inferred simple dual-port RAM with a registered read port.
// Provides occupancy count, full/empty, programmable almost-flags and sticky error flags.
module sync_fifo_ram #(
  parameter int DATA_WIDTH    = 36,
  parameter int ADDR_WIDTH    = 9,
  parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  re_i,
  input  logic                  clr_err_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  dout_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AFULL_C  = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = AEMPTY_THRESH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dout_valid_q;
  logic                  full_q, empty_q, almost_full_q, almost_empty_q;
  logic                  overflow_q, underflow_q;
  logic                  overflow_d, underflow_d;
  logic                  wr_en, rd_en;

  // Acceptance uses only the registered flags, so a read never frees room for a
  // same-cycle write and a write never feeds a same-cycle read.
  assign wr_en = we_i && !full_q;
  assign rd_en = re_i && !empty_q;

  always_comb begin
    count_d = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + 1'b1;
    end else if (rd_en && !wr_en) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr_err_i) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (we_i && full_q) begin
      overflow_d = 1'b1;
    end
    if (re_i && empty_q) begin
      underflow_d = 1'b1;
    end
  end

  // Storage is left unreset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) begin
      mem[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_q <= '0;
    end else if (rd_en) begin
      dout_q <= mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      dout_valid_q   <= 1'b0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q        <= count_d;
      dout_valid_q   <= rd_en;
      full_q         <= (count_d == DEPTH_C);
      empty_q        <= (count_d == '0);
      almost_full_q  <= (count_d >= AFULL_C);
      almost_empty_q <= (count_d <= AEMPTY_C);
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  assign dout_o         = dout_q;
  assign dout_valid_o   = dout_valid_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = almost_full_q;
  assign almost_empty_o = almost_empty_q;
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule
